c_ram_arbiter: RTL and testbench
================================

# c_ram_arbiter

Sequences and shares the single-port data RAM between the compressed-instruction load/store units (CI/CL loads, CSS/CS stores) and a loader/debug port. Performs round-robin arbitration, registers and drives the RAM strobes and word address, waits the RAM read latency, and returns read data with a one-cycle acknowledge per requester. Sits between the RV32C execution units and the data RAM, replacing their direct RAM strobes.

## Interface
- N_REQ, 3, number of requesters (2..4); index 0 = CI/CL load, 1 = CSS/CS store, 2 = loader
- RD_LAT, 1, RAM read latency in cycles after the strobe cycle (1..4)
- AW, 8, RAM word-address width
- iCLK  in  1  clock, all state on rising edge
- iRST_N  in  1  reset, asynchronous, active-low
- iREQ  in  N_REQ  request per requester; held high with its fields stable until its oACK
- iWR  in  N_REQ  1 = write, 0 = read, per requester
- iADDR  in  32*N_REQ  byte address per requester, slice i = [32*i+31:32*i]
- iWDATA  in  32*N_REQ  write data per requester, same slicing
- oACK  out  N_REQ  one-cycle completion pulse, at most one bit set
- oERR  out  1  valid with oACK; 1 = misaligned access, not performed
- oRDATA  out  32  read data, valid with oACK for a read; held until next read completes
- oGNT_ID  out  clog2(N_REQ)  index of the requester currently being served
- oRAM_CE, oRAM_RD, oRAM_WR  out  1 each  RAM strobes
- oRAM_ADDR  out  AW  word address = iADDR[AW+1:2] of winner
- oRAM_DATA  out  32  write data to RAM
- iRAM_DATA  in  32  read data from RAM

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: when any iREQ set, pick winner (round-robin), latch its WR/ADDR/WDATA and index; go to ISSUE. Misaligned (iADDR[1:0] != 0): skip ISSUE, go to DONE with error flag set.
- ISSUE: one cycle, oRAM_CE=1, oRAM_RD=~WR, oRAM_WR=WR, address/data from latch. Write -> DONE. Read -> WAIT.
- WAIT: counter loaded with RD_LAT-1 on entry; at count 0 capture iRAM_DATA into oRDATA, -> DONE. For RD_LAT=1 WAIT lasts exactly one cycle.
- DONE: oACK[winner]=1, oERR=error flag. Arbitrate again in the same cycle with the acked requester masked; any remaining request -> latch and ISSUE (or DONE again if misaligned), else IDLE.
- Round-robin: pointer = last winner; priority order ptr+1, ptr+2, ... mod N_REQ. Pointer updates on each grant (including misaligned).
- Strobes low in IDLE, WAIT, DONE. oRAM_ADDR/oRAM_DATA hold last latched values.
- A requester dropping iREQ before oACK is a protocol violation; access already latched completes and is acked regardless.

## Timing
- Reset (async assert): state IDLE, oACK=0, oERR=0, oRDATA=0, oGNT_ID=0, all RAM outputs 0, pointer = N_REQ-1 (requester 0 wins first). In-flight access abandoned, no ack.
- Write: req seen in IDLE cycle T -> strobe T+1 -> oACK T+2.
- Read: req at T -> strobe T+1 -> data captured at end of T+1+RD_LAT -> oACK T+2+RD_LAT.
- Back-to-back: second access strobes in the cycle after the first oACK (DONE -> ISSUE); write throughput one access per 2 cycles.
- Misaligned: req at T -> oACK+oERR at T+1, no RAM strobe.
- All outputs registered.

## Structure
- Package c_ram_arb_pkg: state enum (IDLE, ISSUE, WAIT, DONE), state width, RD_LAT bounds.
- Sub-module rr_pick: combinational round-robin selector (iREQ, mask, pointer -> valid, index); instanced once.
- Single FSM plus latch registers and latency counter in the top.

## Test plan
- Reset mid-read (assert iRST_N=0 during WAIT) -> all outputs 0, no oACK, next req from 1 served first after req 0 if both high.
- Single write req1, addr 0x0000_0010, data 0xDEAD_BEEF -> oRAM_WR=1, oRAM_ADDR=0x04 at T+1, oACK=3'b010 at T+2, oERR=0.
- Single read req0, addr 0x20, RD_LAT=2, RAM returns 0x1234_5678 -> oRAM_RD at T+1, oACK=3'b001 with oRDATA=0x1234_5678 at T+4.
- All three requesting continuously from reset -> grant order 0,1,2,0,1,2; no requester granted twice consecutively while others pending.
- Misaligned read req2 addr 0x0000_0003 -> no strobe, oACK=3'b100, oERR=1 at T+1; oRDATA unchanged.
- Write req0 then req1 pending during DONE -> req1 strobe the cycle after req0's oACK, no IDLE cycle between.

Source files
------------

// File: rtl/c_ram_arbiter_pkg.sv
// c_ram_arbiter shared types: FSM states, latency bounds
// and the alignment helper used at grant time.
package c_ram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_e;

  localparam int STATE_W    = 2;
  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 4;
  localparam int CNT_W      = 2;

  function automatic logic misaligned(input logic [1:0] lo);
    return lo != 2'b00;
  endfunction

endpackage

// File: rtl/c_ram_arbiter_if.sv
// Requester and RAM-side bus of the data RAM arbiter.
// slave = arbiter view, master = requester/RAM view.
interface c_ram_arbiter_if #(
  parameter int N_REQ = 3,
  parameter int AW    = 8
);
  localparam int GW = $clog2(N_REQ);

  logic [N_REQ-1:0]    iREQ;
  logic [N_REQ-1:0]    iWR;
  logic [32*N_REQ-1:0] iADDR;
  logic [32*N_REQ-1:0] iWDATA;
  logic [N_REQ-1:0]    oACK;
  logic                oERR;
  logic [31:0]         oRDATA;
  logic [GW-1:0]       oGNT_ID;
  logic                oRAM_CE;
  logic                oRAM_RD;
  logic                oRAM_WR;
  logic [AW-1:0]       oRAM_ADDR;
  logic [31:0]         oRAM_DATA;
  logic [31:0]         iRAM_DATA;

  modport slave (
    input  iREQ, iWR, iADDR, iWDATA, iRAM_DATA,
    output oACK, oERR, oRDATA, oGNT_ID,
    output oRAM_CE, oRAM_RD, oRAM_WR,
    output oRAM_ADDR, oRAM_DATA
  );

  modport master (
    output iREQ, iWR, iADDR, iWDATA, iRAM_DATA,
    input  oACK, oERR, oRDATA, oGNT_ID,
    input  oRAM_CE, oRAM_RD, oRAM_WR,
    input  oRAM_ADDR, oRAM_DATA
  );

endinterface

// File: rtl/c_ram_arbiter_rr_pick.sv
// Combinational round-robin selector: first eligible
// requester after the pointer, wrapping modulo N.
module rr_pick #(
  parameter int N = 3,
  parameter int W = 2
) (
  input  logic [N-1:0] req_i,
  input  logic [N-1:0] mask_i,
  input  logic [W-1:0] ptr_i,
  output logic         vld_o,
  output logic [W-1:0] idx_o
);
  localparam int SW = W + 1;

  logic [N-1:0]  elig;
  logic [SW-1:0] s;

  assign elig = req_i & ~mask_i;

  // Scan lowest priority first so the nearest hit wins.
  always_comb begin
    vld_o = 1'b0;
    idx_o = '0;
    s     = '0;
    for (int k = N; k >= 1; k--) begin
      s = {1'b0, ptr_i} + SW'(k);
      if (s >= SW'(N)) s = s - SW'(N);
      if (elig[s[W-1:0]]) begin
        vld_o = 1'b1;
        idx_o = s[W-1:0];
      end
    end
  end

endmodule

// File: rtl/c_ram_arbiter.sv
// Shares the single-port data RAM between the RV32C
// load/store units and the loader port, round-robin.
module c_ram_arbiter
  import c_ram_arb_pkg::*;
#(
  parameter int N_REQ  = 3,
  parameter int RD_LAT = 1,
  parameter int AW     = 8
) (
  input logic           iCLK,
  input logic           iRST_N,
  c_ram_arbiter_if.slave bus
);
  localparam int GW = $clog2(N_REQ);

  state_e state_q, state_d;

  logic [GW-1:0]    ptr_q, ptr_d;
  logic [GW-1:0]    gnt_q, gnt_d;
  logic             wr_q, wr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic             err_q, err_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             ce_q, ce_d;
  logic             rd_q, rd_d;
  logic             rw_q, rw_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;

  logic [N_REQ-1:0] mask;
  logic             pick_vld;
  logic [GW-1:0]    pick_idx;
  logic [AW+1:0]    sel_addr;
  logic [31:0]      sel_wdata;
  logic             sel_wr;

  always_comb begin
    mask = '0;
    if (state_q == DONE) mask[gnt_q] = 1'b1;
  end

  rr_pick #(
    .N (N_REQ),
    .W (GW)
  ) u_pick (
    .req_i  (bus.iREQ),
    .mask_i (mask),
    .ptr_i  (ptr_q),
    .vld_o  (pick_vld),
    .idx_o  (pick_idx)
  );

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_wr    = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_idx == GW'(i)) begin
        sel_addr  = bus.iADDR[32*i +: AW+2];
        sel_wdata = bus.iWDATA[32*i +: 32];
        sel_wr    = bus.iWR[i];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    wr_d    = wr_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    ack_d   = '0;
    err_d   = 1'b0;
    ce_d    = 1'b0;
    rd_d    = 1'b0;
    rw_d    = 1'b0;

    unique case (state_q)
      IDLE: ;
      ISSUE: begin
        if (wr_q) begin
          state_d      = DONE;
          ack_d[gnt_q] = 1'b1;
        end else begin
          state_d = WAIT;
          cnt_d   = CNT_W'(RD_LAT - 1);
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          rdata_d      = bus.iRAM_DATA;
          state_d      = DONE;
          ack_d[gnt_q] = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Grant from IDLE, or chain straight out of DONE.
    if ((state_q == IDLE || state_q == DONE) && pick_vld) begin
      gnt_d   = pick_idx;
      ptr_d   = pick_idx;
      wr_d    = sel_wr;
      addr_d  = sel_addr[AW+1:2];
      wdata_d = sel_wdata;
      if (misaligned(sel_addr[1:0])) begin
        state_d         = DONE;
        ack_d[pick_idx] = 1'b1;
        err_d           = 1'b1;
      end else begin
        state_d = ISSUE;
        ce_d    = 1'b1;
        rd_d    = ~sel_wr;
        rw_d    = sel_wr;
      end
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q <= IDLE;
      ptr_q   <= GW'(N_REQ - 1);
      gnt_q   <= '0;
      wr_q    <= 1'b0;
      cnt_q   <= '0;
      ack_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      ce_q    <= 1'b0;
      rd_q    <= 1'b0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      ce_q    <= ce_d;
      rd_q    <= rd_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign bus.oACK      = ack_q;
  assign bus.oERR      = err_q;
  assign bus.oRDATA    = rdata_q;
  assign bus.oGNT_ID   = gnt_q;
  assign bus.oRAM_CE   = ce_q;
  assign bus.oRAM_RD   = rd_q;
  assign bus.oRAM_WR   = rw_q;
  assign bus.oRAM_ADDR = addr_q;
  assign bus.oRAM_DATA = wdata_q;

endmodule

// File: tb/tb_c_ram_arbiter.sv
// Bench for c_ram_arbiter: vector table, corner sequences
// and a randomized run against a round-robin reference.
module tb_c_ram_arbiter;
  localparam int N  = 3;
  localparam int RL = 2;
  localparam int AW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  c_ram_arbiter_if #(.N_REQ(N), .AW(AW)) bus ();

  c_ram_arbiter #(
    .N_REQ  (N),
    .RD_LAT (RL),
    .AW     (AW)
  ) dut (
    .iCLK   (clk),
    .iRST_N (rst_n),
    .bus    (bus)
  );

  // Behavioural RAM: data appears RL cycles after the strobe.
  logic [31:0] mem [0:255];
  logic [31:0] pipe [0:RL-1];

  always @(posedge clk) begin
    if (bus.oRAM_CE && bus.oRAM_WR) mem[bus.oRAM_ADDR] <= bus.oRAM_DATA;
    pipe[0] <= (bus.oRAM_CE && bus.oRAM_RD) ? mem[bus.oRAM_ADDR] : 32'hBAD0BAD0;
    for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
  end
  assign bus.iRAM_DATA = pipe[RL-1];

  int n_pass = 0;
  int n_chk  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  task automatic set_req(input int i, input logic w, input logic [31:0] a, input logic [31:0] d);
    bus.iREQ[i] = 1'b1;
    bus.iWR[i] = w;
    bus.iADDR[32*i +: 32] = a;
    bus.iWDATA[32*i +: 32] = d;
  endtask

  function automatic int oh2i(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic pulse_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    int          idx;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  ack;
    logic        err;
    logic [31:0] rdata;
    int          lat;
    logic [7:0]  waddr;
  } vec_t;

  vec_t tv [8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int got, c, ns, sc, k, exp_i, lat, arb, cyc, last, st_cyc, j;
    logic s_rd, s_wr;
    logic [7:0] s_addr, st_addr;
    logic [31:0] s_data, rdv, st_data;
    logic [2:0] seen;
    logic [2:0] ord [0:5];
    logic pend [N];
    int rcyc [N];
    logic pw [N];
    logic [31:0] pa [N];
    logic [31:0] pd [N];
    logic [31:0] shadow [0:255];
    logic mis, st_wr, abort;

    for (int i = 0; i < 256; i++) mem[i] = 32'hA5000000 | i;
    mem[8] = 32'h12345678;
    for (int i = 0; i < 256; i++) shadow[i] = 32'hA5000000 | i;
    for (int i = 0; i < RL; i++) pipe[i] = '0;
    bus.iREQ = '0;
    bus.iWR = '0;
    bus.iADDR = '0;
    bus.iWDATA = '0;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_ack", bus.oACK, 0);
    chk("rst_err", bus.oERR, 0);
    chk("rst_rdata", bus.oRDATA, 0);
    chk("rst_gnt", bus.oGNT_ID, 0);
    chk("rst_strb", {bus.oRAM_CE, bus.oRAM_RD, bus.oRAM_WR}, 0);
    chk("rst_addr", bus.oRAM_ADDR, 0);
    chk("rst_data", bus.oRAM_DATA, 0);
    rst_n = 1'b1;
    @(negedge clk);

    tv[0] = '{1, 1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 1'b0, 32'h0, 2, 8'h04};
    tv[1] = '{0, 1'b0, 32'h20, 32'h0, 3'b001, 1'b0, 32'h12345678, 2+RL, 8'h08};
    tv[2] = '{2, 1'b0, 32'h3, 32'h0, 3'b100, 1'b1, 32'h12345678, 1, 8'h00};
    tv[3] = '{2, 1'b0, 32'h10, 32'h0, 3'b100, 1'b0, 32'hDEADBEEF, 2+RL, 8'h04};
    tv[4] = '{0, 1'b1, 32'h3FC, 32'hCAFEF00D, 3'b001, 1'b0, 32'hDEADBEEF, 2, 8'hFF};
    tv[5] = '{1, 1'b0, 32'h3FC, 32'h0, 3'b010, 1'b0, 32'hCAFEF00D, 2+RL, 8'hFF};
    tv[6] = '{1, 1'b1, 32'h102, 32'h77777777, 3'b010, 1'b1, 32'hCAFEF00D, 1, 8'h00};
    tv[7] = '{0, 1'b0, 32'h400, 32'h0, 3'b001, 1'b0, 32'hA5000000, 2+RL, 8'h00};

    for (int v = 0; v < 8; v++) begin
      @(negedge clk);
      set_req(tv[v].idx, tv[v].wr, tv[v].addr, tv[v].wdata);
      c = 0; ns = 0; sc = 0; got = 0;
      s_rd = 0; s_wr = 0; s_addr = 0; s_data = 0;
      while (got == 0 && c < 20) begin
        @(negedge clk);
        c++;
        if (bus.oRAM_CE) begin
          ns++; sc = c;
          s_rd = bus.oRAM_RD; s_wr = bus.oRAM_WR;
          s_addr = bus.oRAM_ADDR; s_data = bus.oRAM_DATA;
        end
        if (bus.oACK != 0) got = 1;
      end
      chk($sformatf("v%0d_ack", v), bus.oACK, tv[v].ack);
      chk($sformatf("v%0d_lat", v), c, tv[v].lat);
      chk($sformatf("v%0d_err", v), bus.oERR, tv[v].err);
      chk($sformatf("v%0d_rdata", v), bus.oRDATA, tv[v].rdata);
      chk($sformatf("v%0d_gnt", v), bus.oGNT_ID, tv[v].idx);
      if (tv[v].err) begin
        chk($sformatf("v%0d_nostrobe", v), ns, 0);
      end else begin
        chk($sformatf("v%0d_nstrobe", v), ns, 1);
        chk($sformatf("v%0d_strobe_cyc", v), sc, 1);
        chk($sformatf("v%0d_waddr", v), s_addr, tv[v].waddr);
        chk($sformatf("v%0d_rdwr", v), {s_rd, s_wr}, {~tv[v].wr, tv[v].wr});
        if (tv[v].wr) chk($sformatf("v%0d_wdata", v), s_data, tv[v].wdata);
      end
      bus.iREQ = '0;
    end

    // back-to-back writes: req1 arrives while req0 is in flight
    @(negedge clk);
    @(negedge clk);
    set_req(0, 1'b1, 32'h40, 32'h11111111);
    @(negedge clk);
    chk("bb_s0_ce", bus.oRAM_CE, 1);
    chk("bb_s0_addr", bus.oRAM_ADDR, 8'h10);
    set_req(1, 1'b1, 32'h44, 32'h22222222);
    @(negedge clk);
    chk("bb_ack0", bus.oACK, 3'b001);
    chk("bb_gap_ce", bus.oRAM_CE, 0);
    bus.iREQ[0] = 1'b0;
    @(negedge clk);
    chk("bb_s1_ce", bus.oRAM_CE, 1);
    chk("bb_s1_wr", bus.oRAM_WR, 1);
    chk("bb_s1_addr", bus.oRAM_ADDR, 8'h11);
    chk("bb_s1_data", bus.oRAM_DATA, 32'h22222222);
    chk("bb_s1_gnt", bus.oGNT_ID, 1);
    @(negedge clk);
    chk("bb_ack1", bus.oACK, 3'b010);
    bus.iREQ = '0;
    repeat (2) @(negedge clk);

    // all three requesting continuously from reset
    #2 rst_n = 1'b0;
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 32'h80 + 4*i, i);
    @(negedge clk);
    rst_n = 1'b1;
    got = 0; c = 0;
    while (got < 6 && c < 60) begin
      @(negedge clk);
      c++;
      if (bus.oACK != 0) begin
        ord[got] = bus.oACK;
        got++;
      end
    end
    bus.iREQ = '0;
    last = N - 1;
    for (int i = 0; i < 6; i++) begin
      last = (last + 1) % N;
      chk($sformatf("rr_order%0d", i), ord[i], 3'b001 << last);
    end
    repeat (3) @(negedge clk);

    // reset asserted while a read waits on the RAM
    set_req(0, 1'b0, 32'h20, 32'h0);
    @(negedge clk);
    chk("mid_strobe_rd", bus.oRAM_RD, 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_ack", bus.oACK, 0);
    chk("mid_err", bus.oERR, 0);
    chk("mid_rdata", bus.oRDATA, 0);
    chk("mid_gnt", bus.oGNT_ID, 0);
    chk("mid_strb", {bus.oRAM_CE, bus.oRAM_RD, bus.oRAM_WR}, 0);
    chk("mid_addr", bus.oRAM_ADDR, 0);
    chk("mid_data", bus.oRAM_DATA, 0);
    bus.iREQ = '0;
    @(negedge clk);
    rst_n = 1'b1;
    seen = '0;
    repeat (6) begin
      @(negedge clk);
      seen = seen | bus.oACK;
    end
    chk("mid_noack", seen, 0);
    set_req(0, 1'b0, 32'h20, 32'h0);
    set_req(1, 1'b1, 32'h48, 32'h33333333);
    got = 0; c = 0; rdv = 0;
    ord[0] = 0; ord[1] = 0;
    while (got < 2 && c < 30) begin
      @(negedge clk);
      c++;
      if (bus.oACK != 0) begin
        ord[got] = bus.oACK;
        if (got == 0) rdv = bus.oRDATA;
        bus.iREQ = bus.iREQ & ~bus.oACK;
        got++;
      end
    end
    bus.iREQ = '0;
    chk("mid_first", ord[0], 3'b001);
    chk("mid_second", ord[1], 3'b010);
    chk("mid_rdata2", rdv, 32'h12345678);
    repeat (3) @(negedge clk);

    // randomized traffic against the round-robin reference
    pulse_reset();
    last = N - 1;
    cyc = 0;
    st_cyc = -100; st_addr = 0; st_wr = 0; st_data = 0;
    abort = 0;
    for (int i = 0; i < N; i++) begin
      pend[i] = 0; rcyc[i] = 0; pw[i] = 0; pa[i] = 0; pd[i] = 0;
    end
    for (int t = 0; t < 800 && !abort; t++) begin
      @(negedge clk);
      cyc++;
      if (bus.oRAM_CE) begin
        st_cyc = cyc; st_addr = bus.oRAM_ADDR;
        st_wr = bus.oRAM_WR; st_data = bus.oRAM_DATA;
      end
      k = -1;
      if (bus.oACK != 0) begin
        chk("rnd_onehot", $onehot(bus.oACK), 1);
        k = oh2i(bus.oACK);
        chk("rnd_pend", pend[k], 1);
        if (pend[k]) begin
          mis = pa[k][1:0] != 2'b00;
          lat = mis ? 1 : (pw[k] ? 2 : 2 + RL);
          arb = cyc - lat;
          exp_i = -1;
          for (int m = 1; m <= N; m++) begin
            j = (last + m) % N;
            if (exp_i < 0 && pend[j] && rcyc[j] <= arb) exp_i = j;
          end
          chk("rnd_gnt", k, exp_i);
          chk("rnd_err", bus.oERR, mis);
          if (mis) begin
            chk("rnd_nostrobe", st_cyc <= arb, 1);
          end else begin
            chk("rnd_strobe_cyc", st_cyc, arb + 1);
            chk("rnd_waddr", st_addr, pa[k][9:2]);
            chk("rnd_wr", st_wr, pw[k]);
            if (pw[k]) begin
              chk("rnd_wdata", st_data, pd[k]);
              shadow[pa[k][9:2]] = pd[k];
            end else begin
              chk("rnd_rdata", bus.oRDATA, shadow[pa[k][9:2]]);
            end
          end
          last = exp_i < 0 ? k : exp_i;
          pend[k] = 0;
        end
        bus.iREQ = bus.iREQ & ~bus.oACK;
      end
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && i != k && $urandom_range(0, 2) == 0) begin
          pw[i] = 1'($urandom_range(0, 1));
          pa[i] = 32'(4 * (64 + $urandom_range(0, 15)));
          if ($urandom_range(0, 5) == 0) pa[i] = pa[i] + 32'($urandom_range(1, 3));
          pd[i] = $urandom;
          pend[i] = 1;
          rcyc[i] = cyc;
          set_req(i, pw[i], pa[i], pd[i]);
        end
      end
      for (int i = 0; i < N; i++) begin
        if (pend[i] && cyc - rcyc[i] > 60 && !abort) begin
          n_chk++;
          $display("FAIL rnd_timeout: requester %0d not acked after %0d cycles", i, cyc - rcyc[i]);
          abort = 1;
        end
      end
    end
    bus.iREQ = '0;
    repeat (10) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
